// File: rtl/fft_sdf_stage.sv
// Radix-2 DIF single-path-delay-feedback butterfly stage with a D-entry complex delay line.
// Handshake: a sample is taken on a rising clock edge when di_en and di_rdy are both 1; do_en marks one valid result per cycle.
module fft_sdf_stage #(
    parameter int WIDTH = 16,
    parameter int LOG2D = 7,
    parameter int SCALE = 1,
    localparam int OW = WIDTH + 1 - SCALE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             di_rdy,
    output logic             do_en,
    output logic [OW-1:0]    do_re,
    output logic [OW-1:0]    do_im,
    output logic             do_sel,
    output logic [LOG2D-1:0] do_idx,
    output logic             dbg_state
);

    localparam int D = 1 << LOG2D;

    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t state, state_nx;
    logic [LOG2D:0]   cnt, cnt_nx;
    logic             pending, pending_nx;
    logic [OW-1:0]    dl_re [D];
    logic [OW-1:0]    dl_im [D];
    logic             phase, last_slot, step;
    logic [LOG2D-1:0] slot;
    logic [WIDTH-1:0] in_re, in_im;
    logic [OW-1:0]    rd_re, rd_im;
    logic signed [WIDTH+1:0] a_re, a_im, b_re, b_im;
    logic signed [WIDTH+1:0] sum_re, sum_im, dif_re, dif_im;
    logic             wr_en, out_en, out_sel;
    logic [OW-1:0]    wr_re, wr_im, out_re, out_im;

    // Divide-by-2 with round-half-up; neither mode can overflow OW bits.
    function automatic logic [OW-1:0] scale_fn(input logic signed [WIDTH+1:0] v);
        logic signed [WIDTH+1:0] t;
        logic signed [WIDTH+1:0] r;
        t = v + {{(WIDTH+1){1'b0}}, 1'b1};
        if (SCALE != 0) r = t >>> 1;
        else            r = v;
        return r[OW-1:0];
    endfunction

    assign phase     = cnt[LOG2D];
    assign slot      = cnt[LOG2D-1:0];
    assign last_slot = &slot;
    assign di_rdy    = (state == ST_RUN);
    assign dbg_state = state;

    // Drain steps feed zeros into the delay line.
    assign in_re = (state == ST_DRAIN) ? '0 : di_re;
    assign in_im = (state == ST_DRAIN) ? '0 : di_im;
    assign rd_re = dl_re[slot];
    assign rd_im = dl_im[slot];

    assign a_re   = {{(WIDTH+2-OW){rd_re[OW-1]}}, rd_re};
    assign a_im   = {{(WIDTH+2-OW){rd_im[OW-1]}}, rd_im};
    assign b_re   = {{2{in_re[WIDTH-1]}}, in_re};
    assign b_im   = {{2{in_im[WIDTH-1]}}, in_im};
    assign sum_re = a_re + b_re;
    assign sum_im = a_im + b_im;
    assign dif_re = a_re - b_re;
    assign dif_im = a_im - b_im;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pending_nx = pending;
        step       = 1'b0;
        wr_en      = 1'b0;
        wr_re      = b_re[OW-1:0];
        wr_im      = b_im[OW-1:0];
        out_en     = 1'b0;
        out_sel    = 1'b0;
        out_re     = rd_re;
        out_im     = rd_im;
        case (state)
            ST_RUN: begin
                if (di_en) step = 1'b1;
                else if (!phase && pending) state_nx = ST_DRAIN;
            end
            ST_DRAIN: step = 1'b1;
            default: state_nx = ST_RUN;
        endcase
        if (step) begin
            wr_en  = 1'b1;
            cnt_nx = cnt + 1'b1;
            if (!phase) begin
                // First half: store the new sample, release last frame's difference.
                out_en  = pending;
                out_sel = 1'b1;
                if (last_slot) begin
                    pending_nx = 1'b0;
                    if (state == ST_DRAIN) begin
                        state_nx = ST_RUN;
                        cnt_nx   = '0;
                    end
                end
            end else begin
                out_en  = 1'b1;
                out_re  = scale_fn(sum_re);
                out_im  = scale_fn(sum_im);
                wr_re   = scale_fn(dif_re);
                wr_im   = scale_fn(dif_im);
                if (last_slot) pending_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_RUN;
            cnt     <= '0;
            pending <= 1'b0;
            do_en   <= 1'b0;
            do_re   <= '0;
            do_im   <= '0;
            do_sel  <= 1'b0;
            do_idx  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pending <= pending_nx;
            do_en   <= out_en;
            if (out_en) begin
                do_re  <= out_re;
                do_im  <= out_im;
                do_sel <= out_sel;
                do_idx <= slot;
            end
        end
    end

    // Delay line is never cleared; pending gates any stale contents.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            dl_re[slot] <= wr_re;
            dl_im[slot] <= wr_im;
        end
    end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Directed bench for fft_sdf_stage at D=4: one instance without scaling, one with scaling, sharing stimulus.
module tb_fft_sdf_stage;
    localparam int W   = 16;
    localparam int LG  = 2;
    localparam int OW0 = 17;
    localparam int OW1 = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           di_en = 1'b0;
    logic [W-1:0]   di_re = '0;
    logic [W-1:0]   di_im = '0;

    logic           di_rdy0, do_en0, do_sel0, dbg0;
    logic [OW0-1:0] do_re0, do_im0;
    logic [LG-1:0]  do_idx0;
    logic           di_rdy1, do_en1, do_sel1, dbg1;
    logic [OW1-1:0] do_re1, do_im1;
    logic [LG-1:0]  do_idx1;

    int total = 0;
    int bad = 0;
    int run_cur = 0;
    int run_max = 0;
    int rdy_low = 0;
    logic [39:0] exp0_q[$];
    logic [39:0] exp1_q[$];

    fft_sdf_stage #(.WIDTH(W), .LOG2D(LG), .SCALE(0)) dut0 (
        .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
        .di_rdy(di_rdy0), .do_en(do_en0), .do_re(do_re0), .do_im(do_im0),
        .do_sel(do_sel0), .do_idx(do_idx0), .dbg_state(dbg0)
    );

    fft_sdf_stage #(.WIDTH(W), .LOG2D(LG), .SCALE(1)) dut1 (
        .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
        .di_rdy(di_rdy1), .do_en(do_en1), .do_re(do_re1), .do_im(do_im1),
        .do_sel(do_sel1), .do_idx(do_idx1), .dbg_state(dbg1)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    // scoreboard
    task automatic expect_out(input logic sel, input logic [LG-1:0] idx,
                              input int re0, input int im0, input int re1, input int im1);
        exp0_q.push_back({3'b0, sel, idx, OW0'(re0), OW0'(im0)});
        exp1_q.push_back({5'b0, sel, idx, OW1'(re1), OW1'(im1)});
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (do_en0) begin
                if (exp0_q.size() == 0) check("unexp0", do_en0, 0);
                else check("out0", {3'b0, do_sel0, do_idx0, do_re0, do_im0}, exp0_q.pop_front());
            end
            if (do_en1) begin
                if (exp1_q.size() == 0) check("unexp1", do_en1, 0);
                else check("out1", {5'b0, do_sel1, do_idx1, do_re1, do_im1}, exp1_q.pop_front());
            end
            if (do_en0) run_cur++;
            else run_cur = 0;
            if (run_cur > run_max) run_max = run_cur;
            if (!di_rdy0) rdy_low++;
        end
    end

    // drivers
    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im);
        di_en = 1'b1;
        di_re = re;
        di_im = im;
        @(posedge clock);
        #1;
        di_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en0"},  do_en0,  0);
        check({tag, "_re0"},  do_re0,  0);
        check({tag, "_im0"},  do_im0,  0);
        check({tag, "_sel0"}, do_sel0, 0);
        check({tag, "_idx0"}, do_idx0, 0);
        check({tag, "_rdy0"}, di_rdy0, 1);
        check({tag, "_st0"},  dbg0,    0);
        check({tag, "_en1"},  do_en1,  0);
        check({tag, "_rdy1"}, di_rdy1, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle(2);
        check_reset_outputs("rst");
        reset = 1'b1;
        idle(1);
    endtask

    task automatic end_test(input string tag);
        check({tag, "_left0"}, exp0_q.size(), 0);
        check({tag, "_left1"}, exp1_q.size(), 0);
        exp0_q.delete();
        exp1_q.delete();
    endtask

    // frame re=1..8, im=0: sums 2k+6 / k+3, diffs -4 / -2
    task automatic expect_frame1();
        for (int k = 0; k < 4; k++) expect_out(1'b0, LG'(k), 2*k+6, 0, k+3, 0);
        for (int k = 0; k < 4; k++) expect_out(1'b1, LG'(k), -4, 0, -2, 0);
    endtask

    task automatic send_frame1();
        for (int i = 1; i <= 8; i++) send(W'(i), '0);
    endtask

    initial begin : main
        logic seen;
        do_reset();

        // basic frame followed by an idle drain
        rdy_low = 0;
        expect_frame1();
        send_frame1();
        idle(12);
        check("t1_rdy_low", rdy_low, 4);
        check("t1_rdy_end", di_rdy0, 1);
        end_test("t1");

        // extreme inputs
        for (int k = 0; k < 4; k++) expect_out(1'b0, LG'(k), 65534, -65536, 32767, -32768);
        for (int k = 0; k < 4; k++) expect_out(1'b1, LG'(k), 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) send(16'h7FFF, 16'h8000);
        idle(12);
        end_test("t2");

        // back-to-back frames A and B, then first half of C
        rdy_low = 0;
        run_max = 0;
        expect_frame1();
        exp0_q = exp0_q[0:3];
        exp1_q = exp1_q[0:3];
        for (int k = 0; k < 4; k++) expect_out(1'b1, LG'(k), -4, 0, -2, 0);
        for (int k = 0; k < 4; k++) expect_out(1'b0, LG'(k), 20*k+60, 12-2*k, 10*k+30, 6-k);
        for (int k = 0; k < 4; k++) expect_out(1'b1, LG'(k), -40, 4, -20, 2);
        send_frame1();
        for (int i = 1; i <= 8; i++) send(W'(10*i), W'(9-i));
        for (int i = 0; i < 4; i++) send(W'(100+i), '0);
        idle(8);
        check("t3_run", run_max, 16);
        check("t3_rdy_low", rdy_low, 0);
        end_test("t3");

        // random input gaps give the same results
        do_reset();
        rdy_low = 0;
        expect_frame1();
        for (int i = 1; i <= 8; i++) begin
            send(W'(i), '0);
            if (i < 8) idle($urandom_range(0, 3));
        end
        idle(12);
        check("t4_rdy_low", rdy_low, 4);
        end_test("t4");

        // reset during drain slot 2
        for (int k = 0; k < 4; k++) expect_out(1'b0, LG'(k), 2*k+6, 0, k+3, 0);
        for (int k = 0; k < 2; k++) expect_out(1'b1, LG'(k), -4, 0, -2, 0);
        send_frame1();
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            if (do_en0 && do_sel0 && do_idx0 == 2'd1) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5_seen", seen, 1);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        idle(1);
        reset = 1'b1;
        idle(1);
        end_test("t5");

        // clean frame after the aborted drain
        rdy_low = 0;
        expect_frame1();
        send_frame1();
        idle(12);
        check("t6_rdy_low", rdy_low, 4);
        end_test("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
